ufpu_param: RTL and testbench

UFPU_PARAM -- requirements
Module: ufpu_param

---
 rtl/ufpu_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_ufpu_param.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufpu_param.sv
// ufpu_param: two-stage bit-vector selection unit.
// The unit offers pass, mask, filter, first-set, random, weighted
// round-robin and minimum-select operations over a WIDTH-bit candidate vector.
// Optional feature macro: UFPU_MIN_SELECT_EN enables opcode 110, minimum-metric
// select. When the macro is undefined, opcode 110 returns zero.
module ufpu_param #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned VAL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_vec,
  input  logic [2:0]                 opcode,
  input  logic [$clog2(WIDTH)-1:0]   id,
  input  logic [2:0]                 pred_op,
  input  logic [VAL_W-1:0]           val,
  input  logic [WIDTH*VAL_W-1:0]     metric,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_vec
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CRD_W = VAL_W + 1;

  localparam logic [2:0] OP_PASS  = 3'b000;
  localparam logic [2:0] OP_MASK  = 3'b001;
  localparam logic [2:0] OP_FILT  = 3'b010;
  localparam logic [2:0] OP_FIRST = 3'b011;
  localparam logic [2:0] OP_RAND  = 3'b100;
  localparam logic [2:0] OP_WRR   = 3'b101;
`ifdef UFPU_MIN_SELECT_EN
  localparam logic [2:0] OP_MIN   = 3'b110;
`endif

  // Maximal-length feedback taps (bit n-1 set for tap n), by register length.
  function automatic logic [15:0] f_taps(input int unsigned n);
    case (n)
      2:       f_taps = 16'h0003;
      3:       f_taps = 16'h0006;
      4:       f_taps = 16'h000C;
      5:       f_taps = 16'h0014;
      6:       f_taps = 16'h0030;
      7:       f_taps = 16'h0060;
      8:       f_taps = 16'h00B8;
      9:       f_taps = 16'h0110;
      10:      f_taps = 16'h0240;
      11:      f_taps = 16'h0500;
      12:      f_taps = 16'h0829;
      13:      f_taps = 16'h100D;
      14:      f_taps = 16'h2015;
      15:      f_taps = 16'h6000;
      default: f_taps = 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]      TAPS_ALL = f_taps(IDX_W);
  localparam logic [IDX_W-1:0] TAPS     = TAPS_ALL[IDX_W-1:0];

  // First set index scanning circularly upward from s (s itself included).
  function automatic logic [IDX_W-1:0] f_scan(input logic [WIDTH-1:0] v,
                                               input logic [IDX_W-1:0] s);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] best;
    best = s;
    for (int k = int'(WIDTH) - 1; k >= 0; k--) begin
      idx = s + IDX_W'(k);
      if (v[idx]) best = idx;
    end
    return best;
  endfunction

  function automatic logic [WIDTH-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    return WIDTH'(1) << idx;
  endfunction

  // Unsigned predicate; the two unused encodings are always false.
  function automatic logic f_pred(input logic [VAL_W-1:0] m,
                                  input logic [VAL_W-1:0] v,
                                  input logic [2:0]       sel);
    case (sel)
      3'b000:  f_pred = (m <  v);
      3'b001:  f_pred = (m >  v);
      3'b010:  f_pred = (m <= v);
      3'b011:  f_pred = (m >= v);
      3'b100:  f_pred = (m == v);
      3'b101:  f_pred = (m != v);
      default: f_pred = 1'b0;
    endcase
  endfunction

  // Stage A request registers
  logic                   r_a_full;
  logic [WIDTH-1:0]       r_a_vec;
  logic [2:0]             r_a_op;
  logic [IDX_W-1:0]       r_a_id;
  logic [2:0]             r_a_pred;
  logic [VAL_W-1:0]       r_a_val;
  logic [WIDTH*VAL_W-1:0] r_a_metric;

  // Stage B result registers and arbitration state
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_out_vec;
  logic [IDX_W-1:0]       r_last_id;
  logic [CRD_W-1:0]       r_credit;
  logic [IDX_W-1:0]       r_lfsr;

  logic                   w_b_adv;
  logic                   w_a_adv;
  logic                   w_eval;
  logic                   w_any;
  logic [VAL_W-1:0]       w_weight;
  logic                   w_hold;
  logic [IDX_W-1:0]       w_move_id;
  logic [WIDTH-1:0]       w_result;
  logic                   w_upd;
  logic [IDX_W-1:0]       w_nxt_last;
  logic [CRD_W-1:0]       w_nxt_credit;

  assign w_b_adv   = !r_out_valid || out_ready;
  assign w_a_adv   = !r_a_full || w_b_adv;
  assign w_eval    = r_a_full && w_b_adv;
  assign in_ready  = w_a_adv;
  assign out_valid = r_out_valid;
  assign out_vec   = r_out_vec;

  // Weighted round-robin decision. Credit 0 means nobody holds the grant yet.
  // This is the state right after reset, so the first grant comes from a scan.
  always_comb begin
    w_any     = |r_a_vec;
    w_weight  = r_a_metric[32'(r_last_id) * VAL_W +: VAL_W];
    if (w_weight == '0) w_weight = VAL_W'(1);
    w_hold    = r_a_vec[r_last_id] && (r_credit != '0) &&
                (r_credit < {1'b0, w_weight});
    w_move_id = f_scan(r_a_vec, r_last_id + IDX_W'(1));
  end

`ifdef UFPU_MIN_SELECT_EN
  logic [WIDTH-1:0] w_min_onehot;
  logic             w_min_found;
  logic [IDX_W-1:0] w_min_idx;
  logic [VAL_W-1:0] w_min_val;

  // Smallest metric among set bits; strict compare keeps the lowest index on ties.
  always_comb begin
    w_min_found = 1'b0;
    w_min_idx   = '0;
    w_min_val   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (r_a_vec[i] &&
          (!w_min_found || (r_a_metric[i*VAL_W +: VAL_W] < w_min_val))) begin
        w_min_found = 1'b1;
        w_min_idx   = IDX_W'(i);
        w_min_val   = r_a_metric[i*VAL_W +: VAL_W];
      end
    end
    w_min_onehot = w_min_found ? f_onehot(w_min_idx) : '0;
  end
`endif

  // Result of the request held in stage A, plus the round-robin state update.
  always_comb begin
    w_result     = '0;
    w_upd        = 1'b0;
    w_nxt_last   = r_last_id;
    w_nxt_credit = r_credit;
    case (r_a_op)
      OP_PASS: w_result = r_a_vec;
      OP_MASK: w_result = r_a_vec & f_onehot(r_a_id);
      OP_FILT: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          w_result[i] = r_a_vec[i] &
                        f_pred(r_a_metric[i*VAL_W +: VAL_W], r_a_val, r_a_pred);
        end
      end
      OP_FIRST: if (w_any) w_result = f_onehot(f_scan(r_a_vec, '0));
      OP_RAND:  if (w_any) w_result = f_onehot(f_scan(r_a_vec, r_lfsr));
      OP_WRR: begin
        if (w_any) begin
          w_upd = 1'b1;
          if (w_hold) begin
            w_result     = f_onehot(r_last_id);
            w_nxt_credit = (r_credit == '1) ? r_credit : r_credit + CRD_W'(1);
          end else begin
            w_result     = f_onehot(w_move_id);
            w_nxt_last   = w_move_id;
            w_nxt_credit = CRD_W'(1);
          end
        end
      end
`ifdef UFPU_MIN_SELECT_EN
      OP_MIN:  w_result = w_min_onehot;
`endif
      default: w_result = '0;
    endcase
  end

  // Stage A: capture a request whenever the stage frees up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_full <= 1'b0;
    end else if (w_a_adv) begin
      r_a_full <= in_valid;
      if (in_valid) begin
        r_a_vec    <= in_vec;
        r_a_op     <= opcode;
        r_a_id     <= id;
        r_a_pred   <= pred_op;
        r_a_val    <= val;
        r_a_metric <= metric;
      end
    end
  end

  // Stage B: register the result; hold it while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
    end else if (w_b_adv) begin
      r_out_valid <= r_a_full;
      if (r_a_full) r_out_vec <= w_result;
    end
  end

  // Round-robin state moves only when a WRR result enters stage B.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id <= '0;
      r_credit  <= '0;
    end else if (w_eval && w_upd) begin
      r_last_id <= w_nxt_last;
      r_credit  <= w_nxt_credit;
    end
  end

  // Free-running LFSR for the random grant; the seed keeps it non-zero.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= IDX_W'(1);
    else     r_lfsr <= {r_lfsr[IDX_W-2:0], ^(r_lfsr & TAPS)};
  end

endmodule

// File: tb/tb_ufpu_param.sv
// Testbench for ufpu_param (WIDTH=8, VAL_W=16): scoreboard against a reference model.
`timescale 1ns/1ps
module tb_ufpu_param;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_vec;
  logic [2:0]   opcode;
  logic [2:0]   id;
  logic [2:0]   pred_op;
  logic [15:0]  val;
  logic [127:0] metric;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_vec;

  always #5 clk = ~clk;

  ufpu_param #(.WIDTH(8), .VAL_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .opcode(opcode), .id(id),
    .pred_op(pred_op), .val(val), .metric(metric),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec)
  );

  typedef struct {
    logic [7:0] vec;
    logic [7:0] inv;
    bit         rnd;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] got_log[$];
  int         tests = 0;
  int         fails = 0;
  int         m_last = 0;
  int         m_credit = 0;
  logic [7:0] wrr_seq [0:8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int k, input logic [7:0] e);
    if (k >= got_log.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: result %0d missing, expected 0x%0h", nm, k, e);
    end else begin
      chk(nm, 32'(got_log[k]), 32'(e));
    end
  endtask

  function automatic int mval(input logic [127:0] mt, input int i);
    return int'(mt[i*16 +: 16]);
  endfunction

  // Reference model: each operation computed straight from its definition.
  task automatic model(input logic [2:0] op, input logic [7:0] v, input logic [2:0] idv,
                       input logic [2:0] pr, input logic [15:0] vl,
                       input logic [127:0] mt, output exp_t e);
    int  w;
    int  j;
    int  m;
    int  best;
    bit  pass;
    bit  found;
    e.vec = 8'h00;
    e.inv = v;
    e.rnd = 1'b0;
    case (op)
      3'd0: e.vec = v;
      3'd1: e.vec = v & (8'd1 << idv);
      3'd2: begin
        for (int i = 0; i < 8; i++) begin
          m = mval(mt, i);
          case (pr)
            3'd0:    pass = (m <  int'(vl));
            3'd1:    pass = (m >  int'(vl));
            3'd2:    pass = (m <= int'(vl));
            3'd3:    pass = (m >= int'(vl));
            3'd4:    pass = (m == int'(vl));
            3'd5:    pass = (m != int'(vl));
            default: pass = 1'b0;
          endcase
          e.vec[i] = v[i] & pass;
        end
      end
      3'd3: for (int i = 7; i >= 0; i--) if (v[i]) e.vec = 8'd1 << i;
      3'd4: e.rnd = 1'b1;
      3'd5: begin
        if (v != 8'h00) begin
          w = mval(mt, m_last);
          if (w == 0) w = 1;
          if (m_credit != 0 && v[m_last] && m_credit < w) begin
            e.vec = 8'd1 << m_last;
            if (m_credit < 131071) m_credit++;
          end else begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
              j = (m_last + k) % 8;
              if (!found && v[j]) begin
                found    = 1'b1;
                e.vec    = 8'd1 << j;
                m_last   = j;
                m_credit = 1;
              end
            end
          end
        end
      end
      3'd6: begin
`ifdef UFPU_MIN_SELECT_EN
        best = -1;
        for (int i = 0; i < 8; i++)
          if (v[i] && (best < 0 || mval(mt, i) < mval(mt, best))) best = i;
        if (best >= 0) e.vec = 8'd1 << best;
`else
        best = -1;
        e.vec = 8'h00;
`endif
      end
      default: e.vec = 8'h00;
    endcase
  endtask

  // One cycle of stimulus, applied at the falling edge; records accepted requests.
  task automatic issue(input bit v, input logic [2:0] op, input logic [7:0] vec,
                       input logic [2:0] idv, input logic [2:0] pr, input logic [15:0] vl,
                       input logic [127:0] mt, input bit rdy, input bit rs, output bit acc);
    exp_t e;
    in_valid = v; opcode = op; in_vec = vec; id = idv;
    pred_op = pr; val = vl; metric = mt; out_ready = rdy; rst = rs;
    #1;
    acc = 1'b0;
    if (rs) begin
      sb.delete();
      m_last = 0;
      m_credit = 0;
    end else if (in_valid && in_ready) begin
      model(op, vec, idv, pr, vl, mt, e);
      sb.push_back(e);
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] vec, input logic [2:0] idv,
                      input logic [2:0] pr, input logic [15:0] vl, input logic [127:0] mt);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      issue(1'b1, op, vec, idv, pr, vl, mt, 1'b1, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic idle();
    bit acc;
    issue(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 16'd0, metric, 1'b1, 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    bit acc;
    issue(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 16'd0, 128'd0, 1'b1, 1'b1, acc);
    issue(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 16'd0, 128'd0, 1'b1, 1'b1, acc);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_vec", 32'(out_vec), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
  exp_t       mon_e;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_vec = 8'h00;
  bit         ok;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (!out_valid || out_vec !== prev_vec) begin
            fails++;
            $display("FAIL hold: out_valid=%0d out_vec=0x%0h, required 1 and 0x%0h",
                     out_valid, out_vec, prev_vec);
          end
        end
        if (out_valid && out_ready) begin
          got_log.push_back(out_vec);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got 0x%0h, required no output", out_vec);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.rnd) begin
              if (mon_e.inv == 8'h00) ok = (out_vec == 8'h00);
              else ok = $onehot(out_vec) && ((out_vec & ~mon_e.inv) == 8'h00) &&
                        !(mon_e.inv == 8'hFF && out_vec == 8'h01);
              tests++;
              if (!ok) begin
                fails++;
                $display("FAIL random_grant: got 0x%0h, required a legal grant from 0x%0h",
                         out_vec, mon_e.inv);
              end
            end else begin
              chk("result", 32'(out_vec), 32'(mon_e.vec));
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_vec   = out_vec;
      end
    end
  end

  logic [127:0] mt;
  logic [7:0]   acc_or;
  logic [7:0]   rvec;
  bit           acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; opcode = 3'd0; id = 3'd0;
    pred_op = 3'd0; val = 16'd0; metric = 128'd0; out_ready = 1'b1;
    wrr_seq = '{8'h04, 8'h01, 8'h01, 8'h04, 8'h01, 8'h01, 8'h04, 8'h01, 8'h01};
    @(negedge clk);
    do_reset();

    // Filter with two-cycle latency
    mt = 128'd0;
    for (int i = 0; i < 8; i++) mt[i*16 +: 16] = 16'(i * 10);
    got_log.delete();
    send(3'd2, 8'hFF, 3'd0, 3'd0, 16'd35, mt);
    chk("latency_cycle1", 32'(out_valid), 32'd0);
    idle();
    chk("latency_cycle2", 32'(out_valid), 32'd1);
    drain();
    chk_log("filter_lt35", 0, 8'h0F);

    // Weighted round-robin after reset
    do_reset();
    mt = 128'd0;
    mt[0 +: 16] = 16'd2;
    mt[32 +: 16] = 16'd1;
    got_log.delete();
    for (int i = 0; i < 6; i++) send(3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt);
    drain();
    for (int i = 0; i < 6; i++) chk_log("wrr_seq", i, wrr_seq[i]);

    // Same sequence with a five-cycle consumer stall in the middle
    do_reset();
    got_log.delete();
    for (int i = 0; i < 3; i++) send(3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt);
    for (int i = 0; i < 5; i++) issue(1'b1, 3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt, 1'b0, 1'b0, acc);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) send(3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt);
    drain();
    for (int i = 0; i < 9; i++) chk_log("bp_wrr_seq", i, wrr_seq[i]);

    // Empty first-set and single-candidate random grant
    got_log.delete();
    send(3'd3, 8'h00, 3'd0, 3'd0, 16'd0, mt);
    for (int i = 0; i < 4; i++) begin
      send(3'd4, 8'h80, 3'd0, 3'd0, 16'd0, mt);
      repeat (i) idle();
    end
    drain();
    chk_log("first_empty", 0, 8'h00);
    for (int i = 1; i < 5; i++) chk_log("rand_single", i, 8'h80);

    // Reset with both stages full
    do_reset();
    send(3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt);
    send(3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt);
    issue(1'b1, 3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt, 1'b0, 1'b0, acc);
    issue(1'b1, 3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt, 1'b0, 1'b1, acc);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    got_log.delete();
    send(3'd5, 8'h05, 3'd0, 3'd0, 16'd0, mt);
    drain();
    chk_log("midrst_wrr", 0, 8'h04);
    chk("midrst_count", 32'(got_log.size()), 32'd1);

    // Minimum select with a tie between entries 1 and 2
    mt = {16'd100, 16'd100, 16'd100, 16'd100, 16'd7, 16'd3, 16'd3, 16'd9};
    got_log.delete();
    send(3'd6, 8'h0E, 3'd0, 3'd0, 16'd0, mt);
    drain();
`ifdef UFPU_MIN_SELECT_EN
    chk_log("min_select", 0, 8'h02);
`else
    chk_log("min_select", 0, 8'h00);
`endif

    // Back-to-back random grants on a full vector visit every non-zero LFSR state
    got_log.delete();
    for (int i = 0; i < 14; i++) send(3'd4, 8'hFF, 3'd0, 3'd0, 16'd0, mt);
    drain();
    acc_or = 8'h00;
    foreach (got_log[i]) acc_or = acc_or | got_log[i];
    chk("lfsr_cover", 32'(acc_or), 32'hFE);

    // Randomized traffic with random backpressure
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) mt[i*16 +: 16] = 16'($urandom_range(0, 20));
      case ($urandom_range(0, 3))
        0:       rvec = 8'h00;
        1:       rvec = 8'd1 << $urandom_range(0, 7);
        2:       rvec = 8'hFF;
        default: rvec = 8'($urandom);
      endcase
      issue($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), rvec,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom_range(0, 22)), mt, $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
